// File: rtl/gf2_poly_reducer_pkg.sv
// gf2_red_pkg: shared constants and types for the GF(2)[x] sequential long divider.
//   PW_DEF  - default dividend width (carry-less product of two 116-bit operands)
//   M_DEF   - default modulus degree / remainder width
//   BPC_DEF - default dividend bits consumed per clock
//   NSTEP   - number of stepping cycles at the defaults
//   CNT_W   - step counter width; one spare code so the counter can reach NSTEP
//   state_t - controller states
package gf2_red_pkg;

  localparam int PW_DEF  = 231;
  localparam int M_DEF   = 116;
  localparam int BPC_DEF = 7;
  localparam int NSTEP   = PW_DEF / BPC_DEF;
  localparam int CNT_W   = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf2_poly_reducer_step.sv
// gf2_red_step: one serial step of GF(2)[x] long division by a monic P(x).
// The remainder register shifts in the next dividend bit. The bit that falls
// off the top is the x^M coefficient. When it is set, the implicit x^M term
// cancels, and the low part of P is folded back in with XOR.
// Ports:
//   r_in  [M-1:0] - partial remainder before this step
//   d_bit         - next dividend coefficient, MSB-first order
//   p     [M-1:0] - modulus coefficients x^0..x^(M-1)
//   r_out [M-1:0] - partial remainder after this step
//   fb            - quotient bit produced by this step
module gf2_red_step
  import gf2_red_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic [M-1:0] r_in,
  input  logic         d_bit,
  input  logic [M-1:0] p,
  output logic [M-1:0] r_out,
  output logic         fb
);

  // Shift one coefficient in and conditionally subtract (XOR) the modulus.
  always_comb begin
    fb = r_in[M-1];
    if (fb) begin
      r_out = {r_in[M-2:0], d_bit} ^ p;
    end else begin
      r_out = {r_in[M-2:0], d_bit};
    end
  end

endmodule

// File: rtl/gf2_poly_reducer.sv
// gf2_poly_reducer: sequential GF(2)[x] reducer. It divides a PW-bit
// carry-less product by P(x) = x^M + mod_low(x). Each BUSY cycle consumes BPC
// dividend bits through a chain of gf2_red_step instances.
// Ports:
//   clk, rst            - clock (rising edge) and synchronous active-high reset
//   in_valid / in_ready - job handshake; dividend and mod_low are sampled on accept
//   dividend  [PW-1:0]  - polynomial to reduce, bit i = coefficient of x^i
//   mod_low   [M-1:0]   - low coefficients of the monic modulus
//   out_valid/out_ready - result handshake; the result is held until it is taken
//   remainder [M-1:0]   - dividend mod P
//   quotient  [PW-M-1:0]- dividend div P
module gf2_poly_reducer
  import gf2_red_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int M   = M_DEF,
  parameter int BPC = BPC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   dividend,
  input  logic [M-1:0]    mod_low,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    remainder,
  output logic [PW-M-1:0] quotient
);

  localparam int QW = PW - M;
  localparam int NS = PW / BPC;
  localparam int CW = $clog2(NS + 1);
  // The counter runs one code past the last stepping cycle. That extra BUSY
  // cycle copies R/Q into the output registers, so out_valid rises NS+1
  // edges after the accept edge.
  localparam logic [CW-1:0] LAST_CNT = CW'(NS);

  state_t              state_r;
  state_t              state_next_s;
  logic [PW-1:0]       d_r;
  logic [M-1:0]        p_r;
  logic [M-1:0]        r_r;
  logic [QW-1:0]       q_r;
  logic [CW-1:0]       cnt_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [M-1:0]        remainder_r;
  logic [QW-1:0]       quotient_r;
  logic                in_ready_next_s;
  logic                out_valid_next_s;
  logic                accept_s;
  logic                release_s;
  logic                steps_done_s;
  logic [BPC:0][M-1:0] r_chain_s;
  logic [BPC-1:0]      fb_bits_s;

  assign accept_s     = in_valid && in_ready_r;
  assign release_s    = out_valid_r && out_ready;
  assign steps_done_s = (cnt_r == LAST_CNT);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign remainder = remainder_r;
  assign quotient  = quotient_r;

  // The chain processes BPC steps per cycle. Step k uses dividend bit PW-1-k,
  // and its quotient bit goes to the MSB end of this cycle's group.
  assign r_chain_s[0] = r_r;
  for (genvar k = 0; k < BPC; k++) begin : g_step
    gf2_red_step #(.M(M)) u_step (
      .r_in  (r_chain_s[k]),
      .d_bit (d_r[PW-1-k]),
      .p     (p_r),
      .r_out (r_chain_s[k+1]),
      .fb    (fb_bits_s[BPC-1-k])
    );
  end

  // State and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (steps_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (release_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state and then registered.
  always_comb begin
    in_ready_next_s  = 1'b0;
    out_valid_next_s = 1'b0;
    case (state_next_s)
      IDLE:    in_ready_next_s  = 1'b1;
      DONE:    out_valid_next_s = 1'b1;
      default: begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
      end
    endcase
  end

  // Datapath: accept the job, step the division, and publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r         <= '0;
      p_r         <= '0;
      r_r         <= '0;
      q_r         <= '0;
      cnt_r       <= '0;
      remainder_r <= '0;
      quotient_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            d_r   <= dividend;
            p_r   <= mod_low;
            r_r   <= '0;
            q_r   <= '0;
            cnt_r <= '0;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CW'(1);
          if (steps_done_s) begin
            remainder_r <= r_r;
            quotient_r  <= q_r;
          end else begin
            r_r <= r_chain_s[BPC];
            d_r <= {d_r[PW-BPC-1:0], {BPC{1'b0}}};
            // The early quotient bits are always zero and fall off the top.
            q_r <= {q_r[QW-BPC-1:0], fb_bits_s};
          end
        end
        DONE: begin
          remainder_r <= remainder_r;
          quotient_r  <= quotient_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_reducer.sv
// Directed and random bench for gf2_poly_reducer at its default parameters.
module tb_gf2_poly_reducer;
  import gf2_red_pkg::*;

  localparam int PW  = PW_DEF;
  localparam int M   = M_DEF;
  localparam int QW  = PW_DEF - M_DEF;
  localparam int LAT = 34;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] dividend;
  logic [M-1:0]  mod_low;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  remainder;
  logic [QW-1:0] quotient;

  int n_chk;
  int n_fail;

  logic [PW-1:0]  one_w;
  logic [PW-1:0]  dv;
  logic [PW-1:0]  prod;
  logic [M-1:0]   pfix;
  logic [M-1:0]   a;
  logic [M-1:0]   b;
  logic [127:0]   tmp;
  logic [M-1:0]   exp_rem;
  logic [QW-1:0]  exp_quo;
  logic [M-1:0]   got_rem;
  logic [QW-1:0]  got_quo;
  logic           seen;

  gf2_poly_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .mod_low   (mod_low),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .remainder (remainder),
    .quotient  (quotient)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] clmul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      if (y[i]) r = r ^ ({{(PW-M){1'b0}}, x} << i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] mul_qp(input logic [QW-1:0] q, input logic [M:0] p);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < QW; i++) begin
      if (q[i]) r = r ^ ({{(PW-M-1){1'b0}}, p} << i);
    end
    return r;
  endfunction

  // Textbook division: cancel the leading term from the top degree down.
  task automatic ref_div(input logic [PW-1:0] d, input logic [M-1:0] ml,
                         output logic [M-1:0] rem, output logic [QW-1:0] quo);
    logic [PW-1:0] w;
    logic [PW-1:0] pf;
    w   = d;
    pf  = {{(PW-M-1){1'b0}}, 1'b1, ml};
    quo = '0;
    for (int i = PW - 1; i >= M; i--) begin
      if (w[i]) begin
        w = w ^ (pf << (i - M));
        quo[i-M] = 1'b1;
      end
    end
    rem = w[M-1:0];
  endtask

  task automatic start_job(input string tag, input logic [PW-1:0] d, input logic [M-1:0] ml);
    check({tag, "_ready"}, {{(PW-1){1'b0}}, in_ready}, {{(PW-1){1'b0}}, 1'b1});
    dividend = d;
    mod_low  = ml;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, PW'(cyc), PW'(LAT));
  endtask

  task automatic take_out(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {{(PW-1){1'b0}}, in_ready}, {{(PW-1){1'b0}}, 1'b1});
    check({tag, "_vld_after"}, {{(PW-1){1'b0}}, out_valid}, {PW{1'b0}});
  endtask

  // Full job. Garbage is driven on the inputs while the job is busy; it must be ignored.
  task automatic run_job(input string tag, input logic [PW-1:0] d, input logic [M-1:0] ml,
                         input logic [M-1:0] er, input logic [QW-1:0] eq,
                         output logic [M-1:0] gr, output logic [QW-1:0] gq);
    start_job(tag, d, ml);
    dividend = ~d;
    mod_low  = ~ml;
    in_valid = 1'b1;
    wait_out(tag);
    in_valid = 1'b0;
    gr = remainder;
    gq = quotient;
    check({tag, "_rem"}, PW'(remainder), PW'(er));
    check({tag, "_quo"}, PW'(quotient), PW'(eq));
    take_out(tag);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    mod_low   = '0;
    one_w     = {{(PW-1){1'b0}}, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready",  PW'(in_ready),  PW'(1));
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_remainder", PW'(remainder), PW'(0));
    check("rst_quotient",  PW'(quotient),  PW'(0));

    // Zero dividend.
    run_job("zero", '0, 116'h1, '0, '0, got_rem, got_quo);
    // x^116 mod (x^116 + x^2 + 1).
    run_job("x116", one_w << 116, 116'h5, 116'h5, 115'h1, got_rem, got_quo);
    // x^230 mod (x^116 + 1) = x^114, quotient x^114.
    exp_rem = '0; exp_rem[114] = 1'b1;
    exp_quo = '0; exp_quo[114] = 1'b1;
    run_job("x230", one_w << 230, 116'h1, exp_rem, exp_quo, got_rem, got_quo);
    // P = x^116 (mod_low = 0): the remainder is the low half and the quotient is the high half.
    dv = {115'h1234_5678_9ABC_DEF0_1122_3344_5566, 116'h0A5A_5A5A_0000_FFFF_1234_8765_4321};
    run_job("pxm", dv, 116'h0, dv[M-1:0], dv[PW-1:M], got_rem, got_quo);

    // Degree < M, with the result held in DONE while out_ready stays low.
    start_job("hold", PW'(32'hDEADBEEF), 116'h7);
    wait_out("hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = PW'(i);
      @(posedge clk); #1;
      check("hold_vld", PW'(out_valid), PW'(1));
      check("hold_rem", PW'(remainder), PW'(32'hDEADBEEF));
      check("hold_quo", PW'(quotient),  PW'(0));
      check("hold_rdy", PW'(in_ready),  PW'(0));
    end
    take_out("hold");
    run_job("next", one_w << 116, 116'h5, 116'h5, 115'h1, got_rem, got_quo);

    // Abort mid-BUSY; the reset state appears and no result follows.
    start_job("abort", one_w << 200, 116'h3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rdy", PW'(in_ready),  PW'(1));
    check("abort_vld", PW'(out_valid), PW'(0));
    check("abort_rem", PW'(remainder), PW'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out", PW'(seen), PW'(0));

    // Reset takes priority over in_valid.
    dividend = one_w << 116;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_vs_valid_rdy", PW'(in_ready), PW'(1));

    // Random products reduced by a fixed modulus.
    pfix = 116'h1D | (116'h1 << 61) | (116'h1 << 97);
    for (int n = 0; n < 500; n++) begin
      tmp  = {$urandom, $urandom, $urandom, $urandom};
      a    = tmp[M-1:0];
      tmp  = {$urandom, $urandom, $urandom, $urandom};
      b    = tmp[M-1:0];
      prod = clmul(a, b);
      ref_div(prod, pfix, exp_rem, exp_quo);
      run_job("rnd", prod, pfix, exp_rem, exp_quo, got_rem, got_quo);
      check("rnd_ident", mul_qp(got_quo, {1'b1, pfix}) ^ PW'(got_rem), prod);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
